alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, operand/register width; SHALL be 8 in this design.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 INSTRUCTION  input  32  [31:24] opcode, [23:16] dest, [15:8] src1, [7:0] src2/immediate.
REQ-005 INSTR_VALID  input  1  INSTRUCTION is valid.
REQ-006 INSTR_READY  output  1  block can accept an instruction.
REQ-007 ALU_DATA1  output  8  registered operand 1 to ALU.
REQ-008 ALU_DATA2  output  8  registered operand 2 to ALU.
REQ-009 ALU_SELECT  output  3  registered ALU operation select.
REQ-010 ALU_RESULT  input  8  combinational ALU result.
REQ-011 DONE  output  1  one-cycle completion pulse.
REQ-012 ILLEGAL  output  1  completed instruction was illegal; valid only while DONE=1.
REQ-013 WB_DATA  output  8  value written back; valid only while DONE=1.
REQ-014 RD_ADDR  input  3  debug register-file read address.
REQ-015 RD_DATA  output  8  combinational contents of REG[RD_ADDR].

Function
REQ-016 Internal register file SHALL be 8 x 8-bit (REG[0..7]), one write port, three combinational read ports (src1, src2, debug).
REQ-017 FSM states SHALL be IDLE, DECODE, EXEC, WB.
REQ-018 INSTR_READY SHALL be 1 only in IDLE; handshake occurs on an edge where INSTR_VALID=1 and INSTR_READY=1, capturing INSTRUCTION into an instruction register and moving to DECODE.
REQ-019 INSTR_VALID while INSTR_READY=0 SHALL be ignored; INSTRUCTION changes after handshake SHALL NOT affect the instruction in flight.
REQ-020 Opcode decode: 0x00 LOADI -> SELECT 000, DATA1=immediate; 0x01 MOV -> SELECT 000, DATA1=REG[src1]; 0x02 ADD -> 001; 0x03 AND -> 010; 0x04 OR -> 011; ADD/AND/OR use DATA1=REG[src1], DATA2=REG[src2].
REQ-021 For LOADI/MOV, ALU_DATA2 SHALL be driven 0.
REQ-022 Illegal: opcode > 0x04, or dest[7:3] != 0, or (non-LOADI) src1[7:3] != 0, or (ADD/AND/OR) src2[7:3] != 0.
REQ-023 DECODE -> EXEC (legal): ALU_DATA1/ALU_DATA2/ALU_SELECT registers load at the DECODE->EXEC edge.
REQ-024 DECODE -> WB (illegal): ALU outputs unchanged, ILLEGAL=1, WB_DATA=0, no register write.
REQ-025 EXEC -> WB: ALU_RESULT sampled into WB_DATA at the EXEC->WB edge.
REQ-026 In WB, DONE SHALL be 1 for exactly one cycle; at WB->IDLE edge REG[dest[2:0]] <= WB_DATA if legal.
REQ-027 Latency: handshake edge E0 -> DONE high in the cycle after E2 (legal) or E1 (illegal); INSTR_READY high again after E3 (legal) or E2 (illegal).
REQ-028 Arithmetic SHALL be 8-bit modulo (carry discarded by ALU); block adds no width extension.
REQ-029 Dest equal to a source SHALL read the old value (operands registered before write-back).
REQ-030 Back-to-back: an instruction presented on the first IDLE cycle after WB SHALL see the previous write-back (RAW across instructions honoured).
REQ-031 RD_DATA SHALL reflect a write from the edge after it occurs; no bypass.

Reset
REQ-032 RESET=1 SHALL immediately (asynchronously) force state IDLE, REG[0..7]=0, instruction register=0, ALU_DATA1=0, ALU_DATA2=0, ALU_SELECT=000, WB_DATA=0, DONE=0, ILLEGAL=0.
REQ-033 INSTR_READY SHALL be 1 while RESET=1 is held deasserted in IDLE; during RESET=1 it SHALL be 0.
REQ-034 Reset in any non-IDLE state SHALL abort the instruction with no register write and no DONE pulse.

Verification
REQ-035 LOADI r1,5 then LOADI r2,3 then ADD r3,r1,r2 -> ALU_SELECT=001, ALU_DATA1=5, ALU_DATA2=3, WB_DATA=8, RD_ADDR=3 gives 8.
REQ-036 r1=0xF0, r2=0x3C: AND r4,r1,r2 -> WB_DATA=0x30; OR r5,r1,r2 -> 0xFC; ADD r6,r1,r1 with r1=0x80 -> 0x00.
REQ-037 Opcode 0x07, and ADD with src2=0x09 -> DONE with ILLEGAL=1, WB_DATA=0, all registers unchanged, INSTR_READY back after 3 cycles.
REQ-038 INSTR_VALID held high continuously with 4 instructions -> each accepted only when INSTR_READY=1, 4-cycle spacing, one DONE per instruction.
REQ-039 RESET asserted mid-EXEC of ADD r3 -> no DONE, REG[3]=0, all outputs 0 immediately, INSTR_READY=1 after RESET release.
REQ-040 ADD r1,r1,r1 with r1=7 -> ALU_DATA1=ALU_DATA2=7, REG[1]=14 after WB.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: captures one instruction, decodes it, drives a
// registered operand/select bundle to an external ALU and writes back.
module alu_issue_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           instruction,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] alu_data1,
    output logic [DATA_WIDTH-1:0] alu_data2,
    output logic [2:0]            alu_select,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  done,
    output logic                  illegal,
    output logic [DATA_WIDTH-1:0] wb_data,
    input  logic [2:0]            rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EXEC,
        WB
    } state_t;

    state_t state;

    logic [31:0]           ir;
    logic [DATA_WIDTH-1:0] regs [8];

    logic [7:0]            op;
    logic [7:0]            dest;
    logic [7:0]            src1;
    logic [7:0]            src2;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;

    logic                  is_loadi;
    logic                  is_mov;
    logic                  is_add;
    logic                  is_and;
    logic                  is_or;
    logic                  is_alu;
    logic                  dec_illegal;

    logic [2:0]            dec_sel;
    logic [DATA_WIDTH-1:0] dec_d1;
    logic [DATA_WIDTH-1:0] dec_d2;

    assign op   = ir[31:24];
    assign dest = ir[23:16];
    assign src1 = ir[15:8];
    assign src2 = ir[7:0];
    assign imm  = ir[DATA_WIDTH-1:0];

    assign rs1_val = regs[src1[2:0]];
    assign rs2_val = regs[src2[2:0]];
    assign rd_data = regs[rd_addr];

    assign is_loadi = (op == 8'h00);
    assign is_mov   = (op == 8'h01);
    assign is_add   = (op == 8'h02);
    assign is_and   = (op == 8'h03);
    assign is_or    = (op == 8'h04);
    assign is_alu   = is_add | is_and | is_or;

    assign dec_illegal = (op > 8'h04)
                       | (|dest[7:3])
                       | (~is_loadi & (|src1[7:3]))
                       | (is_alu & (|src2[7:3]));

    // Ready is a pure function of state, gated low while reset is held.
    assign instr_ready = (state == IDLE) & ~reset;

    // Decode the captured instruction into ALU select and operands.
    always_comb begin
        dec_sel = 3'b000;
        dec_d1  = '0;
        dec_d2  = '0;
        unique case (1'b1)
            is_loadi: begin
                dec_d1 = imm;
            end
            is_mov: begin
                dec_d1 = rs1_val;
            end
            is_add: begin
                dec_sel = 3'b001;
                dec_d1  = rs1_val;
                dec_d2  = rs2_val;
            end
            is_and: begin
                dec_sel = 3'b010;
                dec_d1  = rs1_val;
                dec_d2  = rs2_val;
            end
            is_or: begin
                dec_sel = 3'b011;
                dec_d1  = rs1_val;
                dec_d2  = rs2_val;
            end
            default: begin
            end
        endcase
    end

    // Issue FSM with registered outputs and the register file write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ir         <= '0;
            alu_data1  <= '0;
            alu_data2  <= '0;
            alu_select <= 3'b000;
            wb_data    <= '0;
            done       <= 1'b0;
            illegal    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir    <= instruction;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (dec_illegal) begin
                        illegal <= 1'b1;
                        wb_data <= '0;
                        done    <= 1'b1;
                        state   <= WB;
                    end else begin
                        alu_data1  <= dec_d1;
                        alu_data2  <= dec_d2;
                        alu_select <= dec_sel;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    wb_data <= alu_result;
                    done    <= 1'b1;
                    state   <= WB;
                end
                WB: begin
                    if (!illegal) begin
                        regs[dest[2:0]] <= wb_data;
                    end
                    done    <= 1'b0;
                    illegal <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: reference register model,
// scoreboard of expected write-back results, per-feature scenario tasks.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  alu_data1;
    logic [7:0]  alu_data2;
    logic [2:0]  alu_select;
    logic [7:0]  alu_result;
    logic        done;
    logic        illegal;
    logic [7:0]  wb_data;
    logic [2:0]  rd_addr;
    logic [7:0]  rd_data;

    typedef struct packed {
        logic       ill;
        logic [7:0] wb;
    } exp_t;

    exp_t       sb [$];
    exp_t       mon_e;
    logic [7:0] mregs [8];
    int         checks   = 0;
    int         passes   = 0;
    int         done_cnt = 0;

    alu_issue_ctrl #(.DATA_WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_data1   (alu_data1),
        .alu_data2   (alu_data2),
        .alu_select  (alu_select),
        .alu_result  (alu_result),
        .done        (done),
        .illegal     (illegal),
        .wb_data     (wb_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // External combinational ALU.
    always_comb begin
        alu_result = 8'h00;
        case (alu_select)
            3'b000:  alu_result = alu_data1;
            3'b001:  alu_result = alu_data1 + alu_data2;
            3'b010:  alu_result = alu_data1 & alu_data2;
            3'b011:  alu_result = alu_data1 | alu_data2;
            default: alu_result = 8'h00;
        endcase
    end

    // Scoreboard: every DONE pulse is matched against the oldest prediction.
    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt++;
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_done: got done with empty scoreboard, expected no done");
            end else begin
                mon_e = sb.pop_front();
                if ({illegal, wb_data} !== {mon_e.ill, mon_e.wb})
                    $display("FAIL sb_wb: got ill=%b wb=%h, expected ill=%b wb=%h",
                             illegal, wb_data, mon_e.ill, mon_e.wb);
                else
                    passes++;
            end
        end
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] d,
                                        input logic [7:0] s1, input logic [7:0] s2);
        return {op, d, s1, s2};
    endfunction

    task automatic predict(input logic [31:0] i);
        logic [7:0] op, d, s1, s2, a, b, r;
        logic       ill;
        exp_t       e;
        op  = i[31:24];
        d   = i[23:16];
        s1  = i[15:8];
        s2  = i[7:0];
        ill = (op > 8'h04) || (d[7:3] != 0) ||
              (op != 8'h00 && s1[7:3] != 0) ||
              (op >= 8'h02 && op <= 8'h04 && s2[7:3] != 0);
        a = mregs[s1[2:0]];
        b = mregs[s2[2:0]];
        case (op)
            8'h00:   r = s2;
            8'h01:   r = a;
            8'h02:   r = a + b;
            8'h03:   r = a & b;
            8'h04:   r = a | b;
            default: r = 8'h00;
        endcase
        if (ill) r = 8'h00;
        else mregs[d[2:0]] = r;
        e.ill = ill;
        e.wb  = r;
        sb.push_back(e);
    endtask

    task automatic send(input logic [31:0] i);
        int n;
        n = 0;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (instr_ready !== 1'b1)
            $display("FAIL send_ready: ready=%b, expected 1", instr_ready);
        else
            passes++;
        instruction = i;
        instr_valid = 1'b1;
        predict(i);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instruction = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        checks++;
        if (done !== 1'b1)
            $display("FAIL done_timeout: done=%b, expected 1", done);
        else
            passes++;
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        instr_valid = 1'b0;
        instruction = 32'h0;
        rd_addr     = 3'd0;
        for (int r = 0; r < 8; r++) mregs[r] = 8'h00;
        #1 reset = 1'b1;
        #2;
        checks++;
        if (instr_ready !== 1'b0)
            $display("FAIL reset_ready: got %b, expected 0", instr_ready);
        else passes++;
        checks++;
        if ({done, illegal, wb_data} !== 10'h000)
            $display("FAIL reset_outs: done=%b ill=%b wb=%h, expected 0 0 00",
                     done, illegal, wb_data);
        else passes++;
        checks++;
        if ({alu_data1, alu_data2, alu_select} !== 19'h0)
            $display("FAIL reset_alu: d1=%h d2=%h sel=%b, expected 00 00 000",
                     alu_data1, alu_data2, alu_select);
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (instr_ready !== 1'b1)
            $display("FAIL reset_release_ready: got %b, expected 1", instr_ready);
        else passes++;
        for (int r = 0; r < 8; r++) begin
            rd_addr = 3'(r);
            #1;
            checks++;
            if (rd_data !== 8'h00)
                $display("FAIL reset_reg%0d: got %h, expected 00", r, rd_data);
            else passes++;
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        int n;
        send(ins(8'h00, 8'h01, 8'h00, 8'h05));
        wait_done(n);
        checks++;
        if (n !== 3)
            $display("FAIL basic_latency: got %0d cycles, expected 3", n);
        else passes++;
        @(negedge clk);
        send(ins(8'h00, 8'h02, 8'h00, 8'h03));
        wait_done(n);
        @(negedge clk);
        send(ins(8'h02, 8'h03, 8'h01, 8'h02));
        rd_addr = 3'd3;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({alu_select, alu_data1, alu_data2} !== {3'b001, 8'h05, 8'h03})
            $display("FAIL basic_alu: sel=%b d1=%h d2=%h, expected 001 05 03",
                     alu_select, alu_data1, alu_data2);
        else passes++;
        @(negedge clk);
        checks++;
        if (done !== 1'b1)
            $display("FAIL basic_done: got %b, expected 1", done);
        else passes++;
        checks++;
        if (rd_data !== 8'h00)
            $display("FAIL basic_no_bypass: got %h, expected 00", rd_data);
        else passes++;
        @(negedge clk);
        checks++;
        if (rd_data !== 8'h08)
            $display("FAIL basic_rd3: got %h, expected 08", rd_data);
        else passes++;
        checks++;
        if (instr_ready !== 1'b1)
            $display("FAIL basic_ready: got %b, expected 1", instr_ready);
        else passes++;
    endtask

    task automatic test_logic();
        logic [31:0] prog [6];
        logic [7:0]  want [3];
        int          n;
        prog[0] = ins(8'h00, 8'h01, 8'h00, 8'hF0);
        prog[1] = ins(8'h00, 8'h02, 8'h00, 8'h3C);
        prog[2] = ins(8'h03, 8'h04, 8'h01, 8'h02);
        prog[3] = ins(8'h04, 8'h05, 8'h01, 8'h02);
        prog[4] = ins(8'h00, 8'h01, 8'h00, 8'h80);
        prog[5] = ins(8'h02, 8'h06, 8'h01, 8'h01);
        want[0] = 8'h30;
        want[1] = 8'hFC;
        want[2] = 8'h00;
        for (int k = 0; k < 6; k++) begin
            send(prog[k]);
            wait_done(n);
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            rd_addr = 3'(k + 4);
            #1;
            checks++;
            if (rd_data !== want[k])
                $display("FAIL logic_reg%0d: got %h, expected %h", k + 4, rd_data, want[k]);
            else passes++;
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [3];
        int          n;
        bad[0] = ins(8'h07, 8'h01, 8'h01, 8'h01);
        bad[1] = ins(8'h02, 8'h03, 8'h01, 8'h09);
        bad[2] = ins(8'h01, 8'h08, 8'h01, 8'h00);
        for (int k = 0; k < 3; k++) begin
            send(bad[k]);
            wait_done(n);
            checks++;
            if (n !== 2)
                $display("FAIL illegal_latency%0d: got %0d, expected 2", k, n);
            else passes++;
            checks++;
            if (instr_ready !== 1'b0)
                $display("FAIL illegal_busy%0d: ready=%b, expected 0", k, instr_ready);
            else passes++;
            @(negedge clk);
            checks++;
            if (instr_ready !== 1'b1)
                $display("FAIL illegal_ready%0d: ready=%b, expected 1", k, instr_ready);
            else passes++;
        end
        for (int r = 0; r < 8; r++) begin
            rd_addr = 3'(r);
            #1;
            checks++;
            if (rd_data !== mregs[r])
                $display("FAIL illegal_reg%0d: got %h, expected %h", r, rd_data, mregs[r]);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prog [4];
        int          hs [4];
        int          idx, cyc, d0, n;
        prog[0] = ins(8'h00, 8'h07, 8'h00, 8'h11);
        prog[1] = ins(8'h01, 8'h00, 8'h07, 8'h00);
        prog[2] = ins(8'h02, 8'h07, 8'h07, 8'h00);
        prog[3] = ins(8'h04, 8'h00, 8'h00, 8'h07);
        d0  = done_cnt;
        idx = 0;
        cyc = 0;
        instruction = prog[0];
        instr_valid = 1'b1;
        while (idx < 4 && cyc < 60) begin
            if (instr_ready) begin
                predict(prog[idx]);
                hs[idx] = cyc;
                idx++;
                @(posedge clk);
                #1;
                if (idx < 4) instruction = prog[idx];
            end
            @(negedge clk);
            cyc++;
        end
        instr_valid = 1'b0;
        checks++;
        if (idx !== 4)
            $display("FAIL b2b_accepted: got %0d, expected 4", idx);
        else passes++;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (idx == 4 && hs[k + 1] - hs[k] !== 4)
                $display("FAIL b2b_spacing%0d: got %0d, expected 4", k, hs[k + 1] - hs[k]);
            else if (idx == 4) passes++;
            else $display("FAIL b2b_spacing%0d: not all accepted, expected 4", k);
        end
        wait_done(n);
        @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 4)
            $display("FAIL b2b_dones: got %0d, expected 4", done_cnt - d0);
        else passes++;
        rd_addr = 3'd0;
        #1;
        checks++;
        if (rd_data !== 8'h33)
            $display("FAIL b2b_r0: got %h, expected 33", rd_data);
        else passes++;
        rd_addr = 3'd7;
        #1;
        checks++;
        if (rd_data !== 8'h22)
            $display("FAIL b2b_r7: got %h, expected 22", rd_data);
        else passes++;
    endtask

    task automatic test_same_reg();
        int n;
        send(ins(8'h00, 8'h01, 8'h00, 8'h07));
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({alu_select, alu_data1, alu_data2} !== {3'b000, 8'h07, 8'h00})
            $display("FAIL loadi_alu: sel=%b d1=%h d2=%h, expected 000 07 00",
                     alu_select, alu_data1, alu_data2);
        else passes++;
        wait_done(n);
        @(negedge clk);
        send(ins(8'h02, 8'h01, 8'h01, 8'h01));
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({alu_select, alu_data1, alu_data2} !== {3'b001, 8'h07, 8'h07})
            $display("FAIL same_alu: sel=%b d1=%h d2=%h, expected 001 07 07",
                     alu_select, alu_data1, alu_data2);
        else passes++;
        wait_done(n);
        @(negedge clk);
        rd_addr = 3'd1;
        #1;
        checks++;
        if (rd_data !== 8'h0E)
            $display("FAIL same_r1: got %h, expected 0e", rd_data);
        else passes++;
    endtask

    task automatic test_reset_abort();
        int d0;
        send(ins(8'h02, 8'h03, 8'h01, 8'h01));
        rd_addr = 3'd3;
        @(negedge clk);
        @(negedge clk);
        d0 = done_cnt;
        #1 reset = 1'b1;
        #1;
        sb.delete();
        for (int r = 0; r < 8; r++) mregs[r] = 8'h00;
        checks++;
        if ({alu_data1, alu_data2, alu_select, wb_data} !== 27'h0)
            $display("FAIL abort_outs: d1=%h d2=%h sel=%b wb=%h, expected all 0",
                     alu_data1, alu_data2, alu_select, wb_data);
        else passes++;
        checks++;
        if ({done, illegal, instr_ready} !== 3'b000)
            $display("FAIL abort_ctrl: done=%b ill=%b ready=%b, expected 000",
                     done, illegal, instr_ready);
        else passes++;
        checks++;
        if (rd_data !== 8'h00)
            $display("FAIL abort_r3: got %h, expected 00", rd_data);
        else passes++;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (instr_ready !== 1'b1)
            $display("FAIL abort_ready: got %b, expected 1", instr_ready);
        else passes++;
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt !== d0)
            $display("FAIL abort_no_done: got %0d dones, expected %0d", done_cnt, d0);
        else passes++;
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_basic();
        test_logic();
        test_illegal();
        test_back_to_back();
        test_same_reg();
        test_reset_abort();
        checks++;
        if (sb.size() !== 0)
            $display("FAIL sb_drain: %0d left, expected 0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
